// File: rtl/l2_cache_control_if.sv
// Handshake bundle: upstream request/response and physical-memory line port.
interface l2_cache_control_if;
    logic mem_read;
    logic mem_write;
    logic mem_resp;
    logic pmem_read;
    logic pmem_write;
    logic pmem_resp;

    // Controller side
    modport master (
        input  mem_read, mem_write, pmem_resp,
        output mem_resp, pmem_read, pmem_write
    );

    // Environment side (upstream requester plus memory)
    modport slave (
        output mem_read, mem_write, pmem_resp,
        input  mem_resp, pmem_read, pmem_write
    );
endinterface

// File: rtl/l2_cache_control.sv
// Control FSM for the 8-way, 8-set L2 cache datapath: tag check, hit service,
// dirty-victim writeback and line fill, with PLRU update timing.
package l2_cache_control_pkg;
    typedef enum logic [3:0] {
        cpu           = 4'd0,
        dirty_0_write = 4'd1,
        dirty_1_write = 4'd2,
        dirty_2_write = 4'd3,
        dirty_3_write = 4'd4,
        dirty_4_write = 4'd5,
        dirty_5_write = 4'd6,
        dirty_6_write = 4'd7,
        dirty_7_write = 4'd8
    } pmem_addr_mux_sel_t;

    typedef enum logic {
        cacheline_adaptor = 1'b0,
        bus_adaptor       = 1'b1
    } data_in_mux_sel_t;

    typedef enum logic [1:0] {
        idle      = 2'd0,
        load_mem  = 2'd1,
        cpu_write = 2'd2
    } data_write_en_mux_sel_t;
endpackage

module l2_cache_control
    import l2_cache_control_pkg::*;
#(
    parameter int unsigned num_ways = 8,
    parameter int unsigned way_bits = 3
) (
    input  logic                                    clk,
    input  logic                                    rst,
    l2_cache_control_if.master                      bus,
    input  logic                                    hit,
    input  logic [num_ways-1:0]                     way_hit,
    input  logic [num_ways-1:0]                     valid_out,
    input  logic [num_ways-1:0]                     dirty_out,
    input  logic [way_bits-1:0]                     plru,
    output logic [num_ways-1:0]                     way_load,
    output logic [num_ways-1:0]                     valid_load,
    output logic [num_ways-1:0]                     valid_in,
    output logic [num_ways-1:0]                     dirty_load,
    output logic [num_ways-1:0]                     dirty_in,
    output logic                                    lru_load,
    output logic [way_bits-1:0]                     mru,
    output logic [way_bits-1:0]                     way_sel,
    output pmem_addr_mux_sel_t                      pmem_address_sel,
    output data_in_mux_sel_t       [num_ways-1:0]   way_data_in_sel,
    output data_write_en_mux_sel_t [num_ways-1:0]   way_write_en_sel
);
    typedef enum logic [2:0] {
        st_idle,
        st_check,
        st_writeback,
        st_fill,
        st_settle
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [way_bits-1:0] victim_q;
    logic [way_bits-1:0] hit_way_q;
    logic [way_bits-1:0] hit_way_c;
    logic [way_bits-1:0] victim_c;

    // Hit way: lowest set index of way_hit wins
    always_comb begin
        hit_way_c = '0;
        for (int i = num_ways - 1; i >= 0; i--) begin
            if (way_hit[i]) hit_way_c = way_bits'(i);
        end
    end

    // Victim: lowest invalid way, else the PLRU way when the set is full
    always_comb begin
        victim_c = plru;
        for (int i = num_ways - 1; i >= 0; i--) begin
            if (!valid_out[i]) victim_c = way_bits'(i);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= st_idle;
        else     state <= state_n;
    end

    // Latched hit way (default read-mux select) and latched victim
    always_ff @(posedge clk) begin
        if (rst) begin
            victim_q  <= '0;
            hit_way_q <= '0;
        end else if (state == st_check) begin
            if (hit) hit_way_q <= hit_way_c;
            else     victim_q  <= victim_c;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            st_idle:      if (bus.mem_read || bus.mem_write) state_n = st_check;
            st_check: begin
                if (hit)                                          state_n = st_idle;
                else if (valid_out[victim_c] && dirty_out[victim_c]) state_n = st_writeback;
                else                                              state_n = st_fill;
            end
            st_writeback: if (bus.pmem_resp) state_n = st_fill;
            st_fill:      if (bus.pmem_resp) state_n = st_settle;
            st_settle:    state_n = st_check;
            default:      state_n = st_idle;
        endcase
    end

    // Output logic: datapath selects, array loads and handshakes per state
    always_comb begin
        bus.mem_resp     = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        way_load         = '0;
        valid_load       = '0;
        valid_in         = '0;
        dirty_load       = '0;
        dirty_in         = '0;
        lru_load         = 1'b0;
        mru              = '0;
        way_sel          = hit_way_q;
        pmem_address_sel = cpu;
        for (int i = 0; i < num_ways; i++) begin
            way_data_in_sel[i]  = cacheline_adaptor;
            way_write_en_sel[i] = idle;
        end
        case (state)
            st_check: begin
                if (hit) begin
                    bus.mem_resp = 1'b1;
                    lru_load     = 1'b1;
                    mru          = hit_way_c;
                    if (bus.mem_write) begin
                        way_data_in_sel[hit_way_c]  = bus_adaptor;
                        way_write_en_sel[hit_way_c] = cpu_write;
                        dirty_load[hit_way_c]       = 1'b1;
                        dirty_in[hit_way_c]         = 1'b1;
                    end else begin
                        way_sel = hit_way_c;
                    end
                end
            end
            st_writeback: begin
                bus.pmem_write   = 1'b1;
                pmem_address_sel = pmem_addr_mux_sel_t'(4'(victim_q) + 4'd1);
            end
            st_fill: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    way_data_in_sel[victim_q]  = cacheline_adaptor;
                    way_write_en_sel[victim_q] = load_mem;
                    way_load[victim_q]         = 1'b1;
                    valid_load[victim_q]       = 1'b1;
                    valid_in[victim_q]         = 1'b1;
                    dirty_load[victim_q]       = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_l2_cache_control.sv
// Scoreboard bench for l2_cache_control with a behavioural datapath/tag-array
// model and a fixed-latency memory responder.
module tb_l2_cache_control;
    import l2_cache_control_pkg::*;

    localparam int unsigned L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       hit;
    logic [7:0] way_hit, valid_out, dirty_out;
    logic [2:0] plru;
    logic [7:0] way_load, valid_load, valid_in, dirty_load, dirty_in;
    logic       lru_load;
    logic [2:0] mru, way_sel;
    pmem_addr_mux_sel_t             pmem_address_sel;
    data_in_mux_sel_t       [7:0]   way_data_in_sel;
    data_write_en_mux_sel_t [7:0]   way_write_en_sel;

    l2_cache_control_if bus();

    l2_cache_control dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .hit              (hit),
        .way_hit          (way_hit),
        .valid_out        (valid_out),
        .dirty_out        (dirty_out),
        .plru             (plru),
        .way_load         (way_load),
        .valid_load       (valid_load),
        .valid_in         (valid_in),
        .dirty_load       (dirty_load),
        .dirty_in         (dirty_in),
        .lru_load         (lru_load),
        .mru              (mru),
        .way_sel          (way_sel),
        .pmem_address_sel (pmem_address_sel),
        .way_data_in_sel  (way_data_in_sel),
        .way_write_en_sel (way_write_en_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        int         c0;
        int         lat;
        logic [2:0] way;
        int         fills;
        int         wbs;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          n_fill, n_wb, rcnt;
    bit          hold_resp = 0;
    logic [31:0] addr = 32'h0;
    logic [2:0]  cset;
    logic [23:0] ctag;
    logic [2:0]  exp_victim = 3'd0;
    logic [31:0] exp_wb_addr = 32'h0;

    logic [23:0] tags [8][8];
    logic [7:0]  valid_m [8];
    logic [7:0]  dirty_m [8];
    logic [6:0]  tree [8];

    logic s_rst, s_pr, s_pw, s_presp, s_resp, s_lru, prev_pr, prev_pw;
    logic [7:0] s_wl, s_vl, s_vi, s_dl, s_di;
    logic [2:0] s_mru, s_wsel;
    pmem_addr_mux_sel_t           s_sel;
    data_in_mux_sel_t       [7:0] s_din;
    data_write_en_mux_sel_t [7:0] s_wen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Tree PLRU: node bit 1 means the victim lies in the right subtree
    function automatic logic [2:0] plru_victim(input logic [6:0] b);
        int n = 0;
        for (int l = 0; l < 3; l++) n = 2 * n + 1 + int'(b[n]);
        return 3'(n - 7);
    endfunction

    function automatic logic [6:0] plru_touch(input logic [6:0] b, input logic [2:0] w);
        logic [6:0] r;
        int n;
        r = b;
        n = 0;
        for (int l = 0; l < 3; l++) begin
            r[n] = ~w[2-l];
            n = 2 * n + 1 + int'(w[2-l]);
        end
        return r;
    endfunction

    // Expected outcome of a request against the current model contents
    function automatic exp_t predict(input logic [31:0] a, input bit wr);
        exp_t e;
        logic [2:0]  s;
        logic [23:0] t;
        bit h, found;
        logic [2:0] v;
        s = a[7:5];
        t = a[31:8];
        h = 0;
        e.way = 3'd0;
        for (int w = 7; w >= 0; w--) begin
            if (valid_m[s][w] && tags[s][w] == t) begin
                h = 1;
                e.way = 3'(w);
            end
        end
        e.wr = wr; e.c0 = cyc; e.lat = 1; e.fills = 0; e.wbs = 0;
        if (!h) begin
            found = 0;
            v = plru_victim(tree[s]);
            for (int w = 0; w < 8; w++) begin
                if (!found && !valid_m[s][w]) begin
                    v = 3'(w);
                    found = 1;
                end
            end
            e.way = v;
            e.fills = 1;
            exp_victim = v;
            exp_wb_addr = {tags[s][v], s, 5'b0};
            if (valid_m[s][v] && dirty_m[s][v]) begin
                e.wbs = 1;
                e.lat = 2 * L + 3;
            end else begin
                e.lat = L + 3;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] wb_addr(input pmem_addr_mux_sel_t sel);
        logic [2:0] w;
        w = 3'(4'(sel) - 4'd1);
        return {tags[cset][w], cset, 5'b0};
    endfunction

    task automatic monitor();
        exp_t e;
        logic [7:0] oh;
        check("rw_excl", 32'(s_pr & s_pw), 32'd0);
        if (s_pr && !prev_pr) n_fill++;
        if (s_pw && !prev_pw) n_wb++;
        prev_pr = s_pr;
        prev_pw = s_pw;
        if (s_pw) begin
            check("wb_sel", 32'(s_sel), 32'(exp_victim) + 32'd1);
            check("wb_addr", wb_addr(s_sel), exp_wb_addr);
            check("wb_no_load", 32'(s_wl | s_vl | s_dl), 32'd0);
        end
        if (s_pr) begin
            check("fill_sel", 32'(s_sel), 32'(cpu));
            if (s_presp) begin
                oh = 8'd1 << exp_victim;
                check("fill_way_load", 32'(s_wl), 32'(oh));
                check("fill_valid_load", 32'(s_vl), 32'(oh));
                check("fill_valid_in", 32'(s_vi), 32'(oh));
                check("fill_dirty_load", 32'(s_dl), 32'(oh));
                check("fill_dirty_in", 32'(s_di), 32'd0);
                check("fill_wen", 32'(s_wen[exp_victim]), 32'(load_mem));
                check("fill_din", 32'(s_din[exp_victim]), 32'(cacheline_adaptor));
            end else begin
                check("fill_early_load", 32'(s_wl | s_vl | s_dl), 32'd0);
            end
        end
        if (sb.size() == 0) begin
            check("spurious_resp", 32'(s_resp), 32'd0);
        end else if (s_resp) begin
            e = sb.pop_front();
            oh = 8'd1 << e.way;
            check("latency", 32'(cyc - e.c0), 32'(e.lat));
            check("lru_load", 32'(s_lru), 32'd1);
            check("mru", 32'(s_mru), 32'(e.way));
            check("fill_bursts", 32'(n_fill), 32'(e.fills));
            check("wb_bursts", 32'(n_wb), 32'(e.wbs));
            if (e.wr) begin
                check("wr_wen", 32'(s_wen[e.way]), 32'(cpu_write));
                check("wr_din", 32'(s_din[e.way]), 32'(bus_adaptor));
                check("wr_dirty_load", 32'(s_dl), 32'(oh));
                check("wr_dirty_in", 32'(s_di), 32'(oh));
            end else begin
                check("rd_way_sel", 32'(s_wsel), 32'(e.way));
            end
        end
    endtask

    // Environment: memory responder, datapath model outputs, monitor, array updates
    initial begin
        bus.pmem_resp = 1'b0;
        rcnt = 0;
        prev_pr = 1'b0;
        prev_pw = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.pmem_resp) bus.pmem_resp = 1'b0;
            if (rst) begin
                rcnt = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                rcnt++;
                if (rcnt >= int'(L) && !hold_resp) begin
                    bus.pmem_resp = 1'b1;
                    rcnt = 0;
                end
            end else begin
                rcnt = 0;
            end
            #1;
            cset = addr[7:5];
            ctag = addr[31:8];
            for (int w = 0; w < 8; w++) way_hit[w] = valid_m[cset][w] && (tags[cset][w] == ctag);
            hit       = |way_hit;
            valid_out = valid_m[cset];
            dirty_out = dirty_m[cset];
            plru      = plru_victim(tree[cset]);
            #1;
            s_rst = rst; s_pr = bus.pmem_read; s_pw = bus.pmem_write;
            s_presp = bus.pmem_resp; s_resp = bus.mem_resp; s_lru = lru_load;
            s_wl = way_load; s_vl = valid_load; s_vi = valid_in; s_dl = dirty_load; s_di = dirty_in;
            s_mru = mru; s_wsel = way_sel; s_sel = pmem_address_sel;
            s_din = way_data_in_sel; s_wen = way_write_en_sel;
            if (!s_rst) monitor();
            @(posedge clk);
            cyc++;
            if (!s_rst) begin
                for (int w = 0; w < 8; w++) begin
                    if (s_wl[w]) tags[cset][w] = ctag;
                    if (s_vl[w]) valid_m[cset][w] = s_vi[w];
                    if (s_dl[w]) dirty_m[cset][w] = s_di[w];
                end
                if (s_lru) tree[cset] = plru_touch(tree[cset], s_mru);
            end
        end
    end

    task automatic request(input logic [31:0] a, input bit rd, input bit wr);
        exp_t e;
        @(negedge clk);
        e = predict(a, wr);
        n_fill = 0;
        n_wb = 0;
        sb.push_back(e);
        addr = a;
        bus.mem_read = rd;
        bus.mem_write = wr;
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk);
            #3;
        end
        check("resp_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [2:0] v;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [2:0] v;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        for (int s = 0; s < 8; s++) begin
            valid_m[s] = '0;
            dirty_m[s] = '0;
            tree[s] = '0;
            for (int w = 0; w < 8; w++) tags[s][w] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("rst_mem_resp", 32'(bus.mem_resp), 32'd0);
        check("rst_pmem_read", 32'(bus.pmem_read), 32'd0);
        check("rst_pmem_write", 32'(bus.pmem_write), 32'd0);
        check("rst_lru_load", 32'(lru_load), 32'd0);
        check("rst_way_sel", 32'(way_sel), 32'd0);
        check("rst_mru", 32'(mru), 32'd0);
        check("rst_addr_sel", 32'(pmem_address_sel), 32'(cpu));
        check("rst_loads", 32'(way_load | valid_load | dirty_load), 32'd0);
        check("rst_wen", 32'(way_write_en_sel), 32'd0);

        // Cold read miss fills way 0 clean, then read hit, then write hit
        request(32'h0000_0040, 1'b1, 1'b0);
        check("cold_valid0", 32'(valid_m[2][0]), 32'd1);
        check("cold_dirty0", 32'(dirty_m[2][0]), 32'd0);
        request(32'h0000_0040, 1'b1, 1'b0);
        request(32'h0000_0040, 1'b0, 1'b1);
        check("wr_dirty0", 32'(dirty_m[2][0]), 32'd1);

        // Write-miss the remaining ways of set 2 so every way ends dirty
        for (int k = 1; k < 8; k++) request(32'h0000_0040 + 32'(k) * 32'h100, 1'b0, 1'b1);
        check("set2_full", 32'(valid_m[2]), 32'hFF);
        check("set2_dirty", 32'(dirty_m[2]), 32'hFF);

        // Ninth tag evicts the PLRU way through writeback then fill
        request(32'h0000_0840, 1'b1, 1'b0);
        v = exp_victim;
        check("evict_clean", 32'(dirty_m[2][v]), 32'd0);
        check("evict_tag", 32'(tags[2][v]), 32'd8);

        // Reset while the fill is outstanding
        hold_resp = 1;
        @(negedge clk);
        e = predict(32'h0000_0020, 1'b0);
        addr = 32'h0000_0020;
        bus.mem_read = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #3;
            if (bus.pmem_read) break;
        end
        check("fill_reached", 32'(bus.pmem_read), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hold_resp = 0;
        #3;
        check("rstfill_pmem_read", 32'(bus.pmem_read), 32'd0);
        check("rstfill_mem_resp", 32'(bus.mem_resp), 32'd0);
        check("rstfill_loads", 32'(way_load | valid_load), 32'd0);
        repeat (3) begin
            @(negedge clk);
            #3;
            check("rstfill_idle", 32'(bus.pmem_read | bus.pmem_write), 32'd0);
        end
        check("rstfill_no_write", 32'(valid_m[1]), 32'd0);

        // Retry completes normally; then read+write together acts as a write
        request(32'h0000_0020, 1'b1, 1'b0);
        check("retry_valid", 32'(valid_m[1][0]), 32'd1);
        request(32'h0000_0020, 1'b1, 1'b1);
        check("rw_dirty", 32'(dirty_m[1][0]), 32'd1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
